// File: rtl/issue_scoreboard.sv
// Single-entry issue stage: holds one fetched RV64IM instruction, decodes its register usage
// and releases it to execute only when it is free of RAW/WAW hazards against in-flight writes.
module issue_scoreboard #(
   parameter int NUM_WB = 2,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           ir,
   input  logic                  ir_valid,
   output logic                  ir_ready,
   output logic                  iss_valid,
   input  logic                  iss_ready,
   output logic [31:0]           iss_ir,
   output logic [4:0]            iss_rs1,
   output logic [4:0]            iss_rs2,
   output logic [4:0]            iss_rd,
   output logic                  iss_illegal,
   input  logic [NUM_WB-1:0]     wb_valid,
   input  logic [5*NUM_WB-1:0]   wb_rd,
   input  logic                  flush,
   output logic [31:0]           busy,
   output logic [CNT_W-1:0]      stall_cycles
);

   typedef enum logic {EMPTY, HOLD} state_t;

   state_t            state_q, state_d;
   logic [31:0]       ir_q;
   logic [31:0]       busy_q, busy_d;
   logic [CNT_W-1:0]  stall_q;

   logic              use_rs1, use_rs2, use_rd, illegal;
   logic              hold, hazard, fire, accept, ir_load, stall_inc;
   logic [31:0]       clr, eff_busy, set_mask;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      illegal = 1'b0;
      case (ir_q[6:0])
         7'b0110011, 7'b0111011: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
         end
         7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
            use_rs1 = 1'b1; use_rd = 1'b1;
         end
         7'b0100011, 7'b1100011: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         7'b0110111, 7'b0010111, 7'b1101111: use_rd = 1'b1;
         7'b0001111: ;
         7'b1110011: begin
            // CSR forms: register variants read rs1, immediate variants only write rd
            case (ir_q[14:12])
               3'b001, 3'b010, 3'b011: begin use_rs1 = 1'b1; use_rd = 1'b1; end
               3'b101, 3'b110, 3'b111: use_rd = 1'b1;
               default: ;
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

   assign hold        = (state_q == HOLD);
   assign iss_ir      = hold ? ir_q : 32'd0;
   assign iss_rs1     = (hold && use_rs1) ? ir_q[19:15] : 5'd0;
   assign iss_rs2     = (hold && use_rs2) ? ir_q[24:20] : 5'd0;
   assign iss_rd      = (hold && use_rd)  ? ir_q[11:7]  : 5'd0;
   assign iss_illegal = hold && illegal;

   always_comb begin
      clr = 32'd0;
      for (int k = 0; k < NUM_WB; k++) begin
         if (wb_valid[k]) clr[wb_rd[5*k +: 5]] = 1'b1;
      end
   end

   // Writebacks landing this cycle are bypassed; busy_q[0] is never set, so x0 is hazard-free
   assign eff_busy  = busy_q & ~clr;
   assign hazard    = eff_busy[iss_rs1] | eff_busy[iss_rs2] | eff_busy[iss_rd];
   assign iss_valid = hold && !hazard && !flush;
   assign fire      = iss_valid && iss_ready;
   assign ir_ready  = (!hold || fire) && !flush;
   assign accept    = ir_valid && ir_ready;
   assign stall_inc = hold && hazard && !flush;

   assign set_mask  = (fire && iss_rd != 5'd0) ? (32'd1 << iss_rd) : 32'd0;
   assign busy_d    = (eff_busy | set_mask) & ~32'd1;

   always_comb begin
      state_d = state_q;
      ir_load = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else if (accept) begin
         state_d = HOLD;
         ir_load = 1'b1;
      end else if (fire) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         busy_q  <= 32'd0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         if (stall_inc) stall_q <= sat_inc(stall_q);
      end
   end

   always_ff @(posedge clk) begin
      if (ir_load) ir_q <= ir;
   end

   assign busy         = busy_q;
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: expected issues are queued by the stimulus and
// compared by a monitor whenever an instruction is handed to execute.
module tb_issue_scoreboard;

   localparam int NUM_WB = 2;
   localparam int CNT_W  = 4;

   localparam logic [31:0] ADD3   = 32'h002081B3;
   localparam logic [31:0] ADDI10 = 32'h00A00513;
   localparam logic [31:0] ADDI5  = 32'h00118293;
   localparam logic [31:0] SW     = 32'h00312023;
   localparam logic [31:0] LUI0   = 32'h00000037;
   localparam logic [31:0] ADDI5B = 32'h00700293;
   localparam logic [31:0] ADDI6  = 32'h00028313;
   localparam logic [31:0] ILL    = 32'h0000007F;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [31:0]          ir;
   logic                 ir_valid;
   logic                 ir_ready;
   logic                 iss_valid;
   logic                 iss_ready;
   logic [31:0]          iss_ir;
   logic [4:0]           iss_rs1, iss_rs2, iss_rd;
   logic                 iss_illegal;
   logic [NUM_WB-1:0]    wb_valid;
   logic [5*NUM_WB-1:0]  wb_rd;
   logic                 flush;
   logic [31:0]          busy;
   logic [CNT_W-1:0]     stall_cycles;

   typedef struct {
      logic [31:0] ir;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   issue_scoreboard #(.NUM_WB(NUM_WB), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_ir(iss_ir),
      .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_illegal(iss_illegal),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
      .busy(busy), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] i, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic il);
      exp_t e;
      e.ir = i; e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.ill = il;
      exp_q.push_back(e);
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1; ir_valid = 1'b0; wb_valid = '0; wb_rd = '0; flush = 1'b0;
      nxt();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ir_ready", 32'(ir_ready), 32'd1);
      chk("rst_iss_valid", 32'(iss_valid), 32'd0);
      chk("rst_iss_ir", iss_ir, 32'd0);
      chk("rst_fields", {17'd0, iss_rs1, iss_rs2, iss_rd}, 32'd0);
      chk("rst_illegal", 32'(iss_illegal), 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_stall", 32'(stall_cycles), 32'd0);
      nxt();
   endtask

   // Monitor: every handoff to execute must match the next queued expectation
   always @(negedge clk) begin
      if (!reset && iss_valid && iss_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_issue: got ir 0x%0h, expected no issue", iss_ir);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (iss_ir !== e.ir || iss_rs1 !== e.rs1 || iss_rs2 !== e.rs2 ||
                iss_rd !== e.rd || iss_illegal !== e.ill) begin
               errors++;
               $display("FAIL issue: got ir=%h rs1=%0d rs2=%0d rd=%0d ill=%b, expected ir=%h rs1=%0d rs2=%0d rd=%0d ill=%b",
                        iss_ir, iss_rs1, iss_rs2, iss_rd, iss_illegal,
                        e.ir, e.rs1, e.rs2, e.rd, e.ill);
            end
         end
      end
   end

   initial begin
      iss_ready = 1'b1; ir = 32'd0;
      do_reset();

      // Back-to-back independent instructions
      ir_valid = 1'b1; ir = ADD3; push(ADD3, 5'd1, 5'd2, 5'd3, 1'b0);
      nxt();
      ir = ADDI10; push(ADDI10, 5'd0, 5'd0, 5'd10, 1'b0);
      @(negedge clk); chk("b2b_valid0", 32'(iss_valid), 32'd1);
      nxt();
      ir_valid = 1'b0;
      @(negedge clk); chk("b2b_valid1", 32'(iss_valid), 32'd1);
      nxt();
      @(negedge clk);
      chk("b2b_busy", busy, 32'h0000_0408);
      chk("b2b_stall", 32'(stall_cycles), 32'd0);
      nxt();

      // RAW stall released by a same-cycle writeback on port 1
      do_reset();
      ir_valid = 1'b1; ir = ADD3; push(ADD3, 5'd1, 5'd2, 5'd3, 1'b0);
      nxt();
      ir = ADDI5; push(ADDI5, 5'd3, 5'd0, 5'd5, 1'b0);
      nxt();
      ir_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("raw_stall_valid", 32'(iss_valid), 32'd0);
         chk("raw_stall_cnt", 32'(stall_cycles), 32'(i));
         nxt();
      end
      wb_valid = 2'b10; wb_rd = {5'd3, 5'd0};
      @(negedge clk); chk("raw_bypass_valid", 32'(iss_valid), 32'd1);
      nxt();
      wb_valid = '0;

      // Store has no rd; lui x0 never marks busy
      ir_valid = 1'b1; ir = SW; push(SW, 5'd2, 5'd3, 5'd0, 1'b0);
      @(negedge clk);
      chk("raw_busy_after", busy, 32'h0000_0020);
      chk("raw_stall_after", 32'(stall_cycles), 32'd3);
      nxt();
      ir = LUI0; push(LUI0, 5'd0, 5'd0, 5'd0, 1'b0);
      @(negedge clk); chk("sw_rd", 32'(iss_rd), 32'd0);
      nxt();

      // WAW stall, then clear and set of x5 in the same cycle
      ir = ADDI5B; push(ADDI5B, 5'd0, 5'd0, 5'd5, 1'b0);
      @(negedge clk);
      chk("sw_busy", busy, 32'h0000_0020);
      chk("lui_rd", 32'(iss_rd), 32'd0);
      nxt();
      ir_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); chk("waw_stall_valid", 32'(iss_valid), 32'd0);
         nxt();
      end
      wb_valid = 2'b01; wb_rd = {5'd0, 5'd5};
      @(negedge clk); chk("waw_release_valid", 32'(iss_valid), 32'd1);
      nxt();
      wb_valid = '0;

      // Flush of a stalled instruction
      ir_valid = 1'b1; ir = ADDI6;
      @(negedge clk);
      chk("waw_busy_setwins", busy, 32'h0000_0020);
      chk("waw_stall_cnt", 32'(stall_cycles), 32'd5);
      nxt();
      ir_valid = 1'b0;
      @(negedge clk); chk("fl_pre_valid", 32'(iss_valid), 32'd0);
      nxt();
      flush = 1'b1; ir_valid = 1'b1; ir = ADDI10;
      @(negedge clk);
      chk("fl_ir_ready", 32'(ir_ready), 32'd0);
      chk("fl_valid", 32'(iss_valid), 32'd0);
      nxt();
      flush = 1'b0; ir_valid = 1'b0;
      @(negedge clk);
      chk("fl_post_valid", 32'(iss_valid), 32'd0);
      chk("fl_post_ready", 32'(ir_ready), 32'd1);
      chk("fl_post_busy", busy, 32'h0000_0020);
      chk("fl_post_stall", 32'(stall_cycles), 32'd6);
      nxt();

      // Mid-operation reset, illegal opcode, counter saturation
      do_reset();
      ir_valid = 1'b1; ir = ILL; push(ILL, 5'd0, 5'd0, 5'd0, 1'b1);
      nxt();
      ir_valid = 1'b0;
      @(negedge clk);
      chk("ill_flag", 32'(iss_illegal), 32'd1);
      chk("ill_valid", 32'(iss_valid), 32'd1);
      nxt();
      ir_valid = 1'b1; ir = ADD3; push(ADD3, 5'd1, 5'd2, 5'd3, 1'b0);
      nxt();
      ir = ADDI5; push(ADDI5, 5'd3, 5'd0, 5'd5, 1'b0);
      nxt();
      ir_valid = 1'b0;
      repeat (20) nxt();
      @(negedge clk);
      chk("sat_stall", 32'(stall_cycles), 32'd15);
      chk("sat_valid", 32'(iss_valid), 32'd0);
      nxt();
      wb_valid = 2'b10; wb_rd = {5'd3, 5'd0};
      @(negedge clk); chk("sat_release", 32'(iss_valid), 32'd1);
      nxt();
      wb_valid = '0;
      @(negedge clk);
      chk("sat_stall_hold", 32'(stall_cycles), 32'd15);
      chk("sat_busy", busy, 32'h0000_0020);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
